// File: rtl/rob_commit_ctrl.sv
// Head/tail sequencer for a 2-wide reorder buffer: allocation, in-order retirement, rollback walk.
// Define ROB_DUAL_COMMIT_EN to retire up to two entries per cycle; otherwise one per cycle.
//
// state | meaning
// RUN   | normal dispatch, completion and retirement
// WALK  | rollback walk from walk_ptr down to stop_idx, two entries per cycle
module rob_commit_ctrl #(
    parameter int ROB_NUM = 64,
    parameter int ROB_SEL = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_valid_1,
    input  logic               alloc_valid_2,
    output logic               alloc_ready,
    output logic [ROB_SEL-1:0] alloc_idx_1,
    output logic [ROB_SEL-1:0] alloc_idx_2,
    input  logic               complete_valid_1,
    input  logic [ROB_SEL-1:0] complete_idx_1,
    input  logic               complete_valid_2,
    input  logic [ROB_SEL-1:0] complete_idx_2,
    input  logic               violation_detected,
    input  logic [ROB_SEL-1:0] violation_idx,
    output logic               commit_valid_1,
    output logic [ROB_SEL-1:0] commit_idx_1,
    output logic               commit_valid_2,
    output logic [ROB_SEL-1:0] commit_idx_2,
    output logic               rollback_valid_1,
    output logic [ROB_SEL-1:0] rollback_idx_1,
    output logic               rollback_valid_2,
    output logic [ROB_SEL-1:0] rollback_idx_2,
    output logic               flush_busy,
    output logic [ROB_SEL:0]   count,
    output logic               rob_full,
    output logic               rob_empty
);

    localparam int CNT_W = ROB_SEL + 1;

    typedef enum logic {
        RUN  = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [ROB_SEL-1:0] head, head_n, tail, tail_n;
    logic [ROB_SEL-1:0] walk_ptr, walk_n, stop_idx, stop_n;
    logic [CNT_W-1:0]   count_n;
    logic [ROB_NUM-1:0] valid, valid_n, done, done_n;

    logic               run;
    logic               viol_acc;
    logic               walk_end;
    logic [ROB_SEL-1:0] head_p1, tail_p1, walk_m1;
    logic [1:0]         n_alloc, n_commit, n_rb;

    assign run      = (state == RUN);
    assign head_p1  = head + ROB_SEL'(1);
    assign tail_p1  = tail + ROB_SEL'(1);
    assign walk_m1  = walk_ptr - ROB_SEL'(1);
    assign viol_acc = run && violation_detected && valid[violation_idx];

    assign alloc_ready = run && (count <= CNT_W'(ROB_NUM - 2)) && !violation_detected;
    assign alloc_idx_1 = tail;
    assign alloc_idx_2 = tail_p1;
    assign n_alloc     = alloc_ready ? ({1'b0, alloc_valid_1} + {1'b0, alloc_valid_2}) : 2'd0;

    assign commit_valid_1 = run && !violation_detected && valid[head] && done[head];
`ifdef ROB_DUAL_COMMIT_EN
    assign commit_valid_2 = commit_valid_1 && valid[head_p1] && done[head_p1];
`else
    assign commit_valid_2 = 1'b0;
`endif
    assign commit_idx_1 = commit_valid_1 ? head : '0;
    assign commit_idx_2 = commit_valid_2 ? head_p1 : '0;
    assign n_commit     = {1'b0, commit_valid_1} + {1'b0, commit_valid_2};

    // Walk emits youngest first; the pair stops early once stop_idx is reached.
    assign rollback_valid_1 = (state == WALK);
    assign rollback_valid_2 = (state == WALK) && (walk_ptr != stop_idx);
    assign rollback_idx_1   = rollback_valid_1 ? walk_ptr : '0;
    assign rollback_idx_2   = rollback_valid_2 ? walk_m1 : '0;
    assign n_rb             = {1'b0, rollback_valid_1} + {1'b0, rollback_valid_2};
    assign walk_end         = (walk_ptr == stop_idx) || (walk_m1 == stop_idx);

    assign flush_busy = (state == WALK);
    assign rob_full   = (count == CNT_W'(ROB_NUM));
    assign rob_empty  = (count == '0);
    assign count_n    = count + CNT_W'(n_alloc) - CNT_W'(n_commit) - CNT_W'(n_rb);

    always_comb begin
        state_n = state;
        head_n  = head;
        tail_n  = tail;
        walk_n  = walk_ptr;
        stop_n  = stop_idx;
        valid_n = valid;
        done_n  = done;
        if (complete_valid_1 && valid[complete_idx_1]) done_n[complete_idx_1] = 1'b1;
        if (complete_valid_2 && valid[complete_idx_2]) done_n[complete_idx_2] = 1'b1;
        case (state)
            RUN: begin
                if (viol_acc) begin
                    stop_n  = violation_idx;
                    walk_n  = tail - ROB_SEL'(1);
                    state_n = WALK;
                end
                if (n_alloc != 2'd0) begin
                    valid_n[tail] = 1'b1;
                    done_n[tail]  = 1'b0;
                end
                if (n_alloc == 2'd2) begin
                    valid_n[tail_p1] = 1'b1;
                    done_n[tail_p1]  = 1'b0;
                end
                tail_n = tail + ROB_SEL'(n_alloc);
                if (commit_valid_1) begin
                    valid_n[head] = 1'b0;
                    done_n[head]  = 1'b0;
                end
                if (commit_valid_2) begin
                    valid_n[head_p1] = 1'b0;
                    done_n[head_p1]  = 1'b0;
                end
                head_n = head + ROB_SEL'(n_commit);
            end
            WALK: begin
                valid_n[walk_ptr] = 1'b0;
                done_n[walk_ptr]  = 1'b0;
                if (rollback_valid_2) begin
                    valid_n[walk_m1] = 1'b0;
                    done_n[walk_m1]  = 1'b0;
                end
                walk_n = walk_ptr - ROB_SEL'(n_rb);
                if (walk_end) begin
                    tail_n  = stop_idx;
                    state_n = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            head     <= '0;
            tail     <= '0;
            walk_ptr <= '0;
            stop_idx <= '0;
            count    <= '0;
            valid    <= '0;
            done     <= '0;
        end else begin
            state    <= state_n;
            head     <= head_n;
            tail     <= tail_n;
            walk_ptr <= walk_n;
            stop_idx <= stop_n;
            count    <= count_n;
            valid    <= valid_n;
            done     <= done_n;
        end
    end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
Head/tail sequencer for the 2-wide reorder buffer. It allocates ROB indices at dispatch and tracks per-entry valid and done bits. It retires completed entries in program order, up to 2 per cycle, and drives commit indices to the ROB and rename stage. On a memory-order violation it runs a multi-cycle rollback walk, youngest to oldest, so rename can restore mappings; the tail is then rewound.

Parameters:
ROB_NUM, 64, number of ROB entries; power of 2, >= 4
ROB_SEL, 6, log2(ROB_NUM); index width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
alloc_valid_1  input  1  dispatch slot 1 requests an entry
alloc_valid_2  input  1  dispatch slot 2 requests an entry
alloc_ready  output  1  allocation accepted this cycle
alloc_idx_1  output  ROB_SEL  index assigned to the first accepted request
alloc_idx_2  output  ROB_SEL  index assigned to the second request (tail+1)
complete_valid_1  input  1  writeback port 1 marks an entry done
complete_idx_1  input  ROB_SEL  writeback port 1 index
complete_valid_2  input  1  writeback port 2 marks an entry done
complete_idx_2  input  ROB_SEL  writeback port 2 index
violation_detected  input  1  squash violation_idx and everything younger
violation_idx  input  ROB_SEL  oldest entry to squash
commit_valid_1  output  1  head entry retires this cycle
commit_idx_1  output  ROB_SEL  index of the retiring head entry
commit_valid_2  output  1  head+1 retires this cycle
commit_idx_2  output  ROB_SEL  index of head+1
rollback_valid_1  output  1  entry squashed this cycle (younger of the pair)
rollback_idx_1  output  ROB_SEL  index of the younger squashed entry
rollback_valid_2  output  1  second squashed entry this cycle
rollback_idx_2  output  ROB_SEL  index of the second squashed entry
flush_busy  output  1  rollback walk in progress
count  output  ROB_SEL+1  occupied entries
rob_full  output  1  count == ROB_NUM
rob_empty  output  1  count == 0

Behaviour:
- Reset: head = 0, tail = 0, count = 0, all valid/done = 0, state RUN. All outputs 0 except rob_empty = 1 and alloc_ready = 1.
- State register: RUN or WALK. walk_ptr is a ROB_SEL-bit register; stop_idx is a ROB_SEL-bit register.
- Allocation (combinational):
  - alloc_ready = (state == RUN) && (ROB_NUM - count >= 2) && !violation_detected.
  - Requests are packed: if only alloc_valid_2 is set, it takes the tail and alloc_idx_1 = tail.
  - alloc_idx_1 = tail; alloc_idx_2 = tail + 1 (mod ROB_NUM).
  - On accept: valid set and done cleared at those slots; tail advances by the number of requests.
- Completion: at the clock edge, done[idx] <= 1 when complete_valid_x is set and valid[idx] == 1. Writes to invalid entries are ignored. Both ports may target any index in the same cycle.
- Commit (combinational from registered state, RUN only, and only when violation_detected is low):
  - commit_valid_1 = valid[head] && done[head].
  - commit_valid_2 = commit_valid_1 && valid[head+1] && done[head+1].
  - Latency: complete in cycle t gives commit visible in cycle t+1.
  - At the edge: committed entries are cleared and head advances by the number committed.
- Count: count_next = count + allocated - committed - rolled back. Simultaneous allocate and commit nets correctly. Wrap-around is by ROB_SEL-bit truncation.
- Violation (RUN only): accepted when violation_detected && valid[violation_idx]; otherwise ignored.
  - On accept: stop_idx <= violation_idx, walk_ptr <= tail - 1, state <= WALK.
  - No commit or allocation occurs in the accepting cycle.
- WALK, per cycle:
  - rollback_idx_1 = walk_ptr, rollback_valid_1 = 1.
  - If walk_ptr != stop_idx: rollback_valid_2 = 1 and rollback_idx_2 = walk_ptr - 1.
  - Emitted entries are invalidated and walk_ptr decrements by the number emitted.
  - When stop_idx is emitted: tail <= stop_idx, state <= RUN.
  - flush_busy = (state == WALK).
  - alloc_ready = 0 and commits = 0 throughout the walk.
  - Completions to still-valid entries are accepted; violations are ignored.
- Squashing the head entry is legal. After the walk: head == tail, count == 0.
- Reset mid-walk: the asynchronous reset wins; everything returns to reset values.

Optional Feature:
ROB_DUAL_COMMIT_EN:
- Defined: dual retirement as described above.
- Undefined: commit_valid_2 and commit_idx_2 are tied to 0, and head advances at most 1 per cycle. Allocation and rollback remain 2-wide.

Test Plan:
- Reset, then alloc both slots for 3 cycles -> alloc_idx pairs 0/1, 2/3, 4/5; count = 6, rob_empty = 0.
- Complete idx 1 then idx 0 -> no commit until idx 0 is done; the next cycle shows commit_valid_1/2 with idx 0/1 and count = 4.
- Fill to 63 entries -> alloc_ready = 0; a single commit (count 62) restores alloc_ready.
- Entries 2..9 valid, violation_idx = 5 -> 2 WALK cycles rollback 9/8, 7/6, then 1 cycle rollback 5 alone; tail = 5, count = 3, flush_busy low after.
- Wrap case: head = 62, tail = 2, violation_idx = 63 -> rollback 1/0, then 63 alone; tail = 63.
- Assert reset during WALK -> head = tail = count = 0, flush_busy = 0 immediately.
